// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned BUS_ADDR_MEM = 32;
    localparam int unsigned PIPE_CNT_W   = 3;

    typedef enum logic [1:0] {
        PIPE_ST_RUN    = 2'b00,
        PIPE_ST_LSTALL = 2'b01,
        PIPE_ST_FLUSH  = 2'b10,
        PIPE_ST_MWAIT  = 2'b11
    } pipe_state_e;

    localparam logic PIPE_HOLD_EN   = 1'b1;
    localparam logic PIPE_HOLD_DIS  = 1'b0;
    localparam logic PIPE_FLUSH_EN  = 1'b1;
    localparam logic PIPE_FLUSH_DIS = 1'b0;

    typedef struct packed {
        logic                    pc_hold;
        logic                    pc_sel;
        logic [BUS_ADDR_MEM-1:0] pc_target;
        logic                    if_id_hold;
        logic                    if_id_flush;
        logic                    id_ex_hold;
        logic                    id_ex_flush;
        logic                    ex_mem_hold;
    } pipe_ctl_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall/redirect counter pair; exists only when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] cnt_stall_o,
    output logic [CNT_W-1:0] cnt_flush_o
);

    logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    always_comb begin
        cnt_stall_d = cnt_stall_q;
        cnt_flush_d = cnt_flush_q;
        if (stall_inc_i && (cnt_stall_q != '1)) cnt_stall_d = cnt_stall_q + CNT_W'(1);
        if (flush_inc_i && (cnt_flush_q != '1)) cnt_flush_d = cnt_flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            cnt_stall_q <= cnt_stall_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign cnt_stall_o = cnt_stall_q;
    assign cnt_flush_o = cnt_flush_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: hazards, branch redirects and memory waits -> per-stage hold/flush.
// Define PIPE_PERF_CNT_EN to build the stall/redirect performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned FLUSH_CYC      = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_bypass,
    input  logic                    jmp_taken,
    input  logic [BUS_ADDR_MEM-1:0] jmp_target,
    input  logic                    instr_rdy,
    input  logic                    mem_req,
    input  logic                    mem_rdy,
    output logic                    pc_hold,
    output logic                    pc_sel,
    output logic [BUS_ADDR_MEM-1:0] pc_target,
    output logic                    if_id_hold,
    output logic                    if_id_flush,
    output logic                    id_ex_hold,
    output logic                    id_ex_flush,
    output logic                    ex_mem_hold,
    output logic [CNT_W-1:0]        cnt_stall,
    output logic [CNT_W-1:0]        cnt_flush
);

    if ((LOAD_STALL_CYC < 1) || (LOAD_STALL_CYC > 7)) begin : g_bad_lsc
        $error("pipe_ctrl: LOAD_STALL_CYC must be in 1..7");
    end
    if ((FLUSH_CYC < 1) || (FLUSH_CYC > 7)) begin : g_bad_fc
        $error("pipe_ctrl: FLUSH_CYC must be in 1..7");
    end

    localparam logic [PIPE_CNT_W-1:0] LSTALL_INIT = PIPE_CNT_W'(LOAD_STALL_CYC - 1);
    localparam logic [PIPE_CNT_W-1:0] FLUSH_INIT  = PIPE_CNT_W'(FLUSH_CYC - 1);

    pipe_state_e             state_q, state_d;
    logic [PIPE_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    jmp_pend_q, jmp_pend_d;
    logic [BUS_ADDR_MEM-1:0] jmp_pend_addr_q, jmp_pend_addr_d;

    pipe_ctl_t               ctl_c;
    logic                    jmp_go;
    logic [BUS_ADDR_MEM-1:0] jmp_addr;
    logic                    mem_wait;

    assign mem_wait = mem_req & ~mem_rdy;

    // Next state and control decode; a memory wait also preempts LSTALL/FLUSH.
    always_comb begin
        ctl_c           = '0;
        state_d         = state_q;
        cnt_d           = cnt_q;
        jmp_pend_d      = jmp_pend_q;
        jmp_pend_addr_d = jmp_pend_addr_q;
        jmp_go          = 1'b0;
        jmp_addr        = '0;

        case (state_q)
            PIPE_ST_RUN, PIPE_ST_LSTALL, PIPE_ST_FLUSH: begin
                if (mem_wait) begin
                    ctl_c.pc_hold     = PIPE_HOLD_EN;
                    ctl_c.if_id_hold  = PIPE_HOLD_EN;
                    ctl_c.id_ex_hold  = PIPE_HOLD_EN;
                    ctl_c.ex_mem_hold = PIPE_HOLD_EN;
                    state_d           = PIPE_ST_MWAIT;
                    if (jmp_taken) begin
                        jmp_pend_d      = 1'b1;
                        jmp_pend_addr_d = jmp_target;
                    end
                end else if (jmp_taken) begin
                    jmp_go   = 1'b1;
                    jmp_addr = jmp_target;
                end else if (state_q == PIPE_ST_LSTALL) begin
                    ctl_c.pc_hold     = PIPE_HOLD_EN;
                    ctl_c.if_id_hold  = PIPE_HOLD_EN;
                    ctl_c.id_ex_flush = PIPE_FLUSH_EN;
                    cnt_d             = cnt_q - PIPE_CNT_W'(1);
                    if (cnt_q == PIPE_CNT_W'(1)) state_d = PIPE_ST_RUN;
                end else if (state_q == PIPE_ST_FLUSH) begin
                    ctl_c.if_id_flush = PIPE_FLUSH_EN;
                    ctl_c.id_ex_flush = PIPE_FLUSH_EN;
                    cnt_d             = cnt_q - PIPE_CNT_W'(1);
                    if (cnt_q == PIPE_CNT_W'(1)) state_d = PIPE_ST_RUN;
                end else if (load_bypass) begin
                    ctl_c.pc_hold     = PIPE_HOLD_EN;
                    ctl_c.if_id_hold  = PIPE_HOLD_EN;
                    ctl_c.id_ex_flush = PIPE_FLUSH_EN;
                    if (LOAD_STALL_CYC > 1) begin
                        state_d = PIPE_ST_LSTALL;
                        cnt_d   = LSTALL_INIT;
                    end
                end else if (!instr_rdy) begin
                    ctl_c.pc_hold     = PIPE_HOLD_EN;
                    ctl_c.if_id_flush = PIPE_FLUSH_EN;
                end
            end
            PIPE_ST_MWAIT: begin
                if (mem_rdy) begin
                    state_d = PIPE_ST_RUN;
                    if (jmp_pend_q) begin
                        jmp_go     = 1'b1;
                        jmp_addr   = jmp_pend_addr_q;
                        jmp_pend_d = 1'b0;
                    end
                end else begin
                    ctl_c.pc_hold     = PIPE_HOLD_EN;
                    ctl_c.if_id_hold  = PIPE_HOLD_EN;
                    ctl_c.id_ex_hold  = PIPE_HOLD_EN;
                    ctl_c.ex_mem_hold = PIPE_HOLD_EN;
                end
            end
            default: state_d = PIPE_ST_RUN;
        endcase

        // Redirect: latest taken target wins and (re)starts the flush window.
        if (jmp_go) begin
            ctl_c.pc_hold     = PIPE_HOLD_DIS;
            ctl_c.pc_sel      = 1'b1;
            ctl_c.pc_target   = jmp_addr;
            ctl_c.if_id_flush = PIPE_FLUSH_EN;
            ctl_c.id_ex_flush = PIPE_FLUSH_EN;
            if (FLUSH_CYC > 1) begin
                state_d = PIPE_ST_FLUSH;
                cnt_d   = FLUSH_INIT;
            end else begin
                state_d = PIPE_ST_RUN;
            end
        end

        if (rst) ctl_c = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= PIPE_ST_RUN;
            cnt_q           <= '0;
            jmp_pend_q      <= 1'b0;
            jmp_pend_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            jmp_pend_q      <= jmp_pend_d;
            jmp_pend_addr_q <= jmp_pend_addr_d;
        end
    end

    assign pc_hold     = ctl_c.pc_hold;
    assign pc_sel      = ctl_c.pc_sel;
    assign pc_target   = ctl_c.pc_target;
    assign if_id_hold  = ctl_c.if_id_hold;
    assign if_id_flush = ctl_c.if_id_flush;
    assign id_ex_hold  = ctl_c.id_ex_hold;
    assign id_ex_flush = ctl_c.id_ex_flush;
    assign ex_mem_hold = ctl_c.ex_mem_hold;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .stall_inc_i (ctl_c.pc_hold),
        .flush_inc_i (ctl_c.pc_sel),
        .cnt_stall_o (cnt_stall),
        .cnt_flush_o (cnt_flush)
    );
`else
    assign cnt_stall = '0;
    assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle reference model plus directed literal checks.
module tb_pipe_ctrl;

    localparam int unsigned LSC = 2;
    localparam int unsigned FC  = 2;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_bypass, jmp_taken, instr_rdy, mem_req, mem_rdy;
    logic [31:0]   jmp_target;
    logic          pc_hold, pc_sel, if_id_hold, if_id_flush;
    logic          id_ex_hold, id_ex_flush, ex_mem_hold;
    logic [31:0]   pc_target;
    logic [CW-1:0] cnt_stall, cnt_flush;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(
        .LOAD_STALL_CYC (LSC),
        .FLUSH_CYC      (FC),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_bypass (load_bypass),
        .jmp_taken   (jmp_taken),
        .jmp_target  (jmp_target),
        .instr_rdy   (instr_rdy),
        .mem_req     (mem_req),
        .mem_rdy     (mem_rdy),
        .pc_hold     (pc_hold),
        .pc_sel      (pc_sel),
        .pc_target   (pc_target),
        .if_id_hold  (if_id_hold),
        .if_id_flush (if_id_flush),
        .id_ex_hold  (id_ex_hold),
        .id_ex_flush (id_ex_flush),
        .ex_mem_hold (ex_mem_hold),
        .cnt_stall   (cnt_stall),
        .cnt_flush   (cnt_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lb, input logic jt, input logic [31:0] tg,
                         input logic ir, input logic mr, input logic md);
        @(posedge clk);
        #1;
        load_bypass = lb;
        jmp_taken   = jt;
        jmp_target  = tg;
        instr_rdy   = ir;
        mem_req     = mr;
        mem_rdy     = md;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Reference model in terms of remaining bubble/flush cycles and a pending redirect.
    int          stall_left, flush_left;
    bit          waiting, pend;
    logic [31:0] pend_addr;
    int unsigned m_stall, m_flush;

    initial begin : model
        int          n_sl, n_fl;
        bit          n_wait, n_pend, r_go;
        logic [31:0] n_paddr, r_addr;
        logic        e_ph, e_ps, e_ifh, e_iff, e_idh, e_idf, e_exh;
        logic [31:0] e_pt, e_cs, e_cf;
        stall_left = 0; flush_left = 0; waiting = 0; pend = 0; pend_addr = '0;
        m_stall = 0; m_flush = 0;
        forever begin
            @(negedge clk);
            {e_ph, e_ps, e_ifh, e_iff, e_idh, e_idf, e_exh} = '0;
            e_pt = '0;
            r_go = 0; r_addr = '0;
            n_sl = stall_left; n_fl = flush_left; n_wait = waiting;
            n_pend = pend; n_paddr = pend_addr;
            if (rst) begin
                n_sl = 0; n_fl = 0; n_wait = 0; n_pend = 0; n_paddr = '0;
                m_stall = 0; m_flush = 0;
                stall_left = 0; flush_left = 0; waiting = 0; pend = 0; pend_addr = '0;
            end else if (waiting) begin
                if (mem_rdy) begin
                    n_wait = 0;
                    if (pend) begin r_go = 1; r_addr = pend_addr; n_pend = 0; end
                end else begin
                    {e_ph, e_ifh, e_idh, e_exh} = '1;
                end
            end else if (mem_req && !mem_rdy) begin
                {e_ph, e_ifh, e_idh, e_exh} = '1;
                n_wait = 1; n_sl = 0; n_fl = 0;
                if (jmp_taken) begin n_pend = 1; n_paddr = jmp_target; end
            end else if (jmp_taken) begin
                r_go = 1; r_addr = jmp_target;
            end else if (flush_left > 0) begin
                e_iff = 1; e_idf = 1; n_fl = flush_left - 1;
            end else if (stall_left > 0) begin
                e_ph = 1; e_ifh = 1; e_idf = 1; n_sl = stall_left - 1;
            end else if (load_bypass) begin
                e_ph = 1; e_ifh = 1; e_idf = 1; n_sl = int'(LSC) - 1;
            end else if (!instr_rdy) begin
                e_ph = 1; e_iff = 1;
            end
            if (r_go) begin
                e_ps = 1; e_pt = r_addr; e_iff = 1; e_idf = 1;
                n_fl = int'(FC) - 1; n_sl = 0;
            end
`ifdef PIPE_PERF_CNT_EN
            e_cs = m_stall; e_cf = m_flush;
`else
            e_cs = 0; e_cf = 0;
`endif
            chk("model_pc_hold", {31'b0, pc_hold}, {31'b0, e_ph});
            chk("model_pc_sel", {31'b0, pc_sel}, {31'b0, e_ps});
            chk("model_pc_target", pc_target, e_pt);
            chk("model_if_id_hold", {31'b0, if_id_hold}, {31'b0, e_ifh});
            chk("model_if_id_flush", {31'b0, if_id_flush}, {31'b0, e_iff});
            chk("model_id_ex_hold", {31'b0, id_ex_hold}, {31'b0, e_idh});
            chk("model_id_ex_flush", {31'b0, id_ex_flush}, {31'b0, e_idf});
            chk("model_ex_mem_hold", {31'b0, ex_mem_hold}, {31'b0, e_exh});
            chk("model_cnt_stall", cnt_stall, e_cs);
            chk("model_cnt_flush", cnt_flush, e_cf);
            @(posedge clk);
            if (!rst) begin
                stall_left = n_sl; flush_left = n_fl; waiting = n_wait;
                pend = n_pend; pend_addr = n_paddr;
                if (e_ph) m_stall++;
                if (e_ps) m_flush++;
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        load_bypass = 0; jmp_taken = 0; jmp_target = '0;
        instr_rdy = 0; mem_req = 0; mem_rdy = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("reset_if_id_flush", {31'b0, if_id_flush}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr_rdy = 1'b1;
        idle(); idle();

        // Load-use hazard, two bubbles
        drive(1, 0, 32'h0, 1, 0, 0); #1;
        chk("lu_c0_pc_hold", {31'b0, pc_hold}, 32'd1);
        chk("lu_c0_id_ex_flush", {31'b0, id_ex_flush}, 32'd1);
        chk("lu_c0_ex_mem_hold", {31'b0, ex_mem_hold}, 32'd0);
        idle(); #1;
        chk("lu_c1_pc_hold", {31'b0, pc_hold}, 32'd1);
        chk("lu_c1_if_id_hold", {31'b0, if_id_hold}, 32'd1);
        idle(); #1;
        chk("lu_c2_pc_hold", {31'b0, pc_hold}, 32'd0);

        // Taken jump to 0x100
        drive(0, 1, 32'h0000_0100, 1, 0, 0); #1;
        chk("jmp_c0_pc_sel", {31'b0, pc_sel}, 32'd1);
        chk("jmp_c0_pc_target", pc_target, 32'h100);
        chk("jmp_c0_if_id_flush", {31'b0, if_id_flush}, 32'd1);
        idle(); #1;
        chk("jmp_c1_pc_sel", {31'b0, pc_sel}, 32'd0);
        chk("jmp_c1_id_ex_flush", {31'b0, id_ex_flush}, 32'd1);
        idle(); #1;
        chk("jmp_c2_if_id_flush", {31'b0, if_id_flush}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_cnt_stall", cnt_stall, 32'd2);
        chk("perf_cnt_flush", cnt_flush, 32'd1);
`endif

        // Memory wait with a jump arriving in its first cycle
        drive(0, 1, 32'h0000_0200, 1, 1, 0); #1;
        chk("mw_c0_pc_hold", {31'b0, pc_hold}, 32'd1);
        chk("mw_c0_ex_mem_hold", {31'b0, ex_mem_hold}, 32'd1);
        chk("mw_c0_pc_sel", {31'b0, pc_sel}, 32'd0);
        drive(0, 1, 32'h0000_0200, 1, 1, 0); #1;
        chk("mw_c1_id_ex_hold", {31'b0, id_ex_hold}, 32'd1);
        drive(0, 0, 32'h0, 1, 1, 0); #1;
        chk("mw_c2_if_id_hold", {31'b0, if_id_hold}, 32'd1);
        drive(0, 0, 32'h0, 1, 1, 1); #1;
        chk("mw_exit_pc_sel", {31'b0, pc_sel}, 32'd1);
        chk("mw_exit_pc_target", pc_target, 32'h200);
        chk("mw_exit_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("mw_exit_ex_mem_hold", {31'b0, ex_mem_hold}, 32'd0);
        idle(); #1;
        chk("mw_post_pc_sel", {31'b0, pc_sel}, 32'd0);
        chk("mw_post_if_id_flush", {31'b0, if_id_flush}, 32'd1);
        idle(); idle();

        // Load hazard and jump together: jump wins
        drive(1, 1, 32'h0000_0400, 1, 0, 0); #1;
        chk("lj_pc_sel", {31'b0, pc_sel}, 32'd1);
        chk("lj_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("lj_if_id_hold", {31'b0, if_id_hold}, 32'd0);
        idle(); #1;
        chk("lj_c1_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("lj_c1_if_id_flush", {31'b0, if_id_flush}, 32'd1);
        idle();

        // Fetch bubble and same-cycle memory completion
        drive(0, 0, 32'h0, 0, 0, 0); #1;
        chk("fb_pc_hold", {31'b0, pc_hold}, 32'd1);
        chk("fb_if_id_flush", {31'b0, if_id_flush}, 32'd1);
        chk("fb_id_ex_flush", {31'b0, id_ex_flush}, 32'd0);
        drive(0, 0, 32'h0, 1, 1, 1); #1;
        chk("mrdy_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("mrdy_ex_mem_hold", {31'b0, ex_mem_hold}, 32'd0);

        // Jump aborts a load stall
        drive(1, 0, 32'h0, 1, 0, 0);
        drive(0, 1, 32'h0000_0500, 1, 0, 0); #1;
        chk("ls_jmp_pc_sel", {31'b0, pc_sel}, 32'd1);
        chk("ls_jmp_pc_hold", {31'b0, pc_hold}, 32'd0);
        idle(); idle();

        // Jump during flush restarts the window with the newest target
        drive(0, 1, 32'h0000_0600, 1, 0, 0);
        drive(0, 1, 32'h0000_0700, 1, 0, 0); #1;
        chk("fr_pc_target", pc_target, 32'h700);
        idle(); #1;
        chk("fr_c1_if_id_flush", {31'b0, if_id_flush}, 32'd1);
        idle(); #1;
        chk("fr_c2_if_id_flush", {31'b0, if_id_flush}, 32'd0);

        // Reset asserted in the middle of a load stall
        drive(1, 0, 32'h0, 1, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        load_bypass = 0;
        #1;
        chk("rst_mid_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("rst_mid_if_id_hold", {31'b0, if_id_hold}, 32'd0);
        chk("rst_mid_id_ex_flush", {31'b0, id_ex_flush}, 32'd0);
        chk("rst_mid_cnt_stall", cnt_stall, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_rel_pc_hold", {31'b0, pc_hold}, 32'd0);
        drive(1, 0, 32'h0, 1, 0, 0); #1;
        chk("rst_rel_lu_pc_hold", {31'b0, pc_hold}, 32'd1);
        idle(); idle();

        // Mixed traffic, checked cycle by cycle against the model
        repeat (300) begin
            drive(($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0);
        end
        repeat (4) idle();
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
